nist_window_test: RTL

NIST_WINDOW_TEST -- requirements
Module: nist_window_test

---
 rtl/nist_pkg.sv | 26 ++
 rtl/nist_window_test_if.sv | 15 +
 rtl/nist_blk_accum.sv | 74 +++++++
 rtl/nist_window_test.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/nist_pkg.sv
// Shared definitions for the NIST window test: FSM state encoding, default
// thresholds and the width helpers used to size counters and the accumulator.
package nist_pkg;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_FINISH  = 2'd1,
      ST_REPORT  = 2'd2
   } nist_state_e;

   localparam int unsigned MONO_TH_DEF = 32'd82;
   localparam int unsigned BLK_TH_DEF  = 32'd428;
   localparam int unsigned RUN_LO_DEF  = 32'd471;
   localparam int unsigned RUN_HI_DEF  = 32'd553;

   // A counter that must reach 2^log2 inclusive needs one extra bit.
   function automatic int unsigned cnt_width(input int unsigned log2);
      return log2 + 32'd1;
   endfunction

   function automatic int unsigned acc_width(input int unsigned seq_log2,
                                             input int unsigned blk_log2);
      return 32'd2 * blk_log2 + seq_log2 - blk_log2;
   endfunction

endpackage

// File: rtl/nist_window_test_if.sv
// Bit-stream input and verdict outputs of the NIST window test.
interface nist_window_test_if;
   logic       bit_valid;
   logic       bit_in;
   logic       win_done;
   logic       err_mono;
   logic       err_blk;
   logic       err_runs;
   logic [7:0] fail_cnt;

   modport master (output bit_valid, bit_in,
                   input  win_done, err_mono, err_blk, err_runs, fail_cnt);
   modport slave  (input  bit_valid, bit_in,
                   output win_done, err_mono, err_blk, err_runs, fail_cnt);
endinterface

// File: rtl/nist_blk_accum.sv
// Block-frequency statistic: per-block ones count, signed deviation from M/2,
// its square, and the running sum of squares over the window.
module nist_blk_accum
   import nist_pkg::*;
#(
   parameter int unsigned SEQ_LOG2 = 32'd10,
   parameter int unsigned BLK_LOG2 = 32'd5
) (
   input  logic clk,
   input  logic rst,
   input  logic accept,
   input  logic bit_in,
   input  logic blk_last,
   input  logic win_last,
   input  logic finish,
   input  logic clear,
   output logic [acc_width(SEQ_LOG2, BLK_LOG2)-1:0] sum_next
);
   localparam int unsigned BW = cnt_width(BLK_LOG2);
   localparam int unsigned AW = acc_width(SEQ_LOG2, BLK_LOG2);
   localparam int unsigned PW = 32'd2 * BW + 32'd2;
   localparam logic [BW:0] HALF = {{BW{1'b0}}, 1'b1} << (BLK_LOG2 - 32'd1);

   logic [BW-1:0]        ones_q, ones_d, ones_inc, dev_src;
   logic [AW-1:0]        sum_q, sum_d;
   logic signed [BW:0]   dev;
   logic signed [PW-1:0] dev_x;
   logic [PW-1:0]        dev_sq;

   // In FINISH the stored count already holds the final block, including its last bit.
   always_comb begin
      ones_inc = ones_q + {{(BW-1){1'b0}}, bit_in};
      dev_src  = finish ? ones_q : ones_inc;
      dev      = $signed({1'b0, dev_src}) - $signed(HALF);
      dev_x    = PW'(dev);
      dev_sq   = $unsigned(dev_x * dev_x);
   end

   // The final block of a window is deferred to FINISH; all others close on their last bit.
   always_comb begin
      ones_d = ones_q;
      sum_d  = sum_q;
      if (clear) begin
         ones_d = {BW{1'b0}};
         sum_d  = {AW{1'b0}};
      end else if (finish) begin
         ones_d = {BW{1'b0}};
         sum_d  = sum_q + AW'(dev_sq);
      end else if (accept) begin
         if (blk_last && !win_last) begin
            ones_d = {BW{1'b0}};
            sum_d  = sum_q + AW'(dev_sq);
         end else begin
            ones_d = ones_inc;
         end
      end else begin
         ones_d = ones_q;
      end
   end

   assign sum_next = sum_d;

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ones_q <= {BW{1'b0}};
         sum_q  <= {AW{1'b0}};
      end else begin
         ones_q <= ones_d;
         sum_q  <= sum_d;
      end
   end

endmodule

// File: rtl/nist_window_test.sv
// Windowed NIST monobit / block-frequency / runs health test on a bit stream.
// Define NIST_RUNS_TEST_EN to build the runs test; otherwise err_runs is tied to 0.
module nist_window_test
   import nist_pkg::*;
#(
   parameter int unsigned SEQ_LOG2 = 32'd10,
   parameter int unsigned BLK_LOG2 = 32'd5,
   parameter int unsigned MONO_TH  = MONO_TH_DEF,
   parameter int unsigned BLK_TH   = BLK_TH_DEF,
   parameter int unsigned RUN_LO   = RUN_LO_DEF,
   parameter int unsigned RUN_HI   = RUN_HI_DEF
) (
   input logic               clk,
   input logic               rst,
   nist_window_test_if.slave bus
);
   localparam int unsigned CW = cnt_width(SEQ_LOG2);
   localparam int unsigned AW = acc_width(SEQ_LOG2, BLK_LOG2);
   localparam logic [CW:0] N_V = {{CW{1'b0}}, 1'b1} << SEQ_LOG2;

   nist_state_e         state_q, state_d;
   logic [SEQ_LOG2-1:0] pos_q, pos_d;
   logic [CW-1:0]       ones_q, ones_d;
   logic                win_done_q, win_done_d;
   logic                err_mono_q, err_mono_d;
   logic                err_blk_q, err_blk_d;
   logic                err_runs_q, err_runs_d;
   logic [7:0]          fail_cnt_q, fail_cnt_d;
   logic                accept, blk_last, win_last, in_finish, in_report;
   logic                mono_fail, blk_fail, runs_fail, any_fail;
   logic [AW-1:0]       blk_sum_next;
   logic [CW:0]         two_ones, mono_abs;

   assign accept    = (state_q == ST_COLLECT) && bus.bit_valid;
   assign blk_last  = &pos_q[BLK_LOG2-1:0];
   assign win_last  = &pos_q;
   assign in_finish = (state_q == ST_FINISH);
   assign in_report = (state_q == ST_REPORT);

   nist_blk_accum #(.SEQ_LOG2(SEQ_LOG2), .BLK_LOG2(BLK_LOG2)) u_blk (
      .clk(clk), .rst(rst), .accept(accept), .bit_in(bus.bit_in),
      .blk_last(blk_last), .win_last(win_last), .finish(in_finish),
      .clear(in_report), .sum_next(blk_sum_next)
   );

   // Window sequencing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_COLLECT: begin
            if (accept && win_last) state_d = ST_FINISH;
            else                    state_d = ST_COLLECT;
         end
         ST_FINISH: state_d = ST_REPORT;
         ST_REPORT: state_d = ST_COLLECT;
         default:   state_d = ST_COLLECT;
      endcase
   end

   // Bit position and ones count; position wraps to 0 after the n-th bit.
   always_comb begin
      pos_d  = pos_q;
      ones_d = ones_q;
      if (in_report) begin
         pos_d  = {SEQ_LOG2{1'b0}};
         ones_d = {CW{1'b0}};
      end else if (accept) begin
         pos_d  = pos_q + {{(SEQ_LOG2-1){1'b0}}, 1'b1};
         ones_d = ones_q + {{(CW-1){1'b0}}, bus.bit_in};
      end else begin
         pos_d  = pos_q;
         ones_d = ones_q;
      end
   end

`ifdef NIST_RUNS_TEST_EN
   logic [CW-1:0] runs_q, runs_d;
   logic          prev_q, prev_d;

   // Run count restarts on the first bit so history never spans windows.
   always_comb begin
      runs_d = runs_q;
      prev_d = prev_q;
      if (in_report) begin
         runs_d = {CW{1'b0}};
         prev_d = 1'b0;
      end else if (accept) begin
         prev_d = bus.bit_in;
         if (pos_q == {SEQ_LOG2{1'b0}})  runs_d = CW'(1'b1);
         else if (bus.bit_in != prev_q) runs_d = runs_q + CW'(1'b1);
         else                           runs_d = runs_q;
      end else begin
         runs_d = runs_q;
      end
   end

   // Runs registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         runs_q <= {CW{1'b0}};
         prev_q <= 1'b0;
      end else begin
         runs_q <= runs_d;
         prev_q <= prev_d;
      end
   end

   assign runs_fail = (32'(runs_q) < RUN_LO) || (32'(runs_q) > RUN_HI);
`else
   logic runs_cfg_unused;
   assign runs_cfg_unused = (RUN_LO > RUN_HI);
   assign runs_fail       = 1'b0;
`endif

   assign two_ones  = {ones_q, 1'b0};
   assign mono_abs  = (two_ones >= N_V) ? (two_ones - N_V) : (N_V - two_ones);
   assign mono_fail = 32'(mono_abs) > MONO_TH;
   assign blk_fail  = 32'(blk_sum_next) > BLK_TH;
   assign any_fail  = mono_fail || blk_fail || runs_fail;

   // Verdicts are taken from FINISH so they land together with win_done.
   always_comb begin
      win_done_d = in_finish;
      err_mono_d = err_mono_q;
      err_blk_d  = err_blk_q;
      err_runs_d = err_runs_q;
      fail_cnt_d = fail_cnt_q;
      if (in_finish) begin
         err_mono_d = mono_fail;
         err_blk_d  = blk_fail;
         err_runs_d = runs_fail;
         if (any_fail && (fail_cnt_q != 8'hFF)) fail_cnt_d = fail_cnt_q + 8'd1;
         else                                   fail_cnt_d = fail_cnt_q;
      end else begin
         fail_cnt_d = fail_cnt_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_COLLECT;
         pos_q      <= {SEQ_LOG2{1'b0}};
         ones_q     <= {CW{1'b0}};
         win_done_q <= 1'b0;
         err_mono_q <= 1'b0;
         err_blk_q  <= 1'b0;
         err_runs_q <= 1'b0;
         fail_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         ones_q     <= ones_d;
         win_done_q <= win_done_d;
         err_mono_q <= err_mono_d;
         err_blk_q  <= err_blk_d;
         err_runs_q <= err_runs_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign bus.win_done = win_done_q;
   assign bus.err_mono = err_mono_q;
   assign bus.err_blk  = err_blk_q;
   assign bus.err_runs = err_runs_q;
   assign bus.fail_cnt = fail_cnt_q;

endmodule
